// File: rtl/wt_mem_req_arbiter_pkg.sv
// Shared types and constants for the N-port write-through memory request arbiter.
package wt_mem_req_arbiter_pkg;

   // Default configuration of the arbiter
   localparam int unsigned DefNumPorts       = 3;
   localparam int unsigned DefAddrWidth      = 64;
   localparam int unsigned DefDataWidth      = 64;
   localparam int unsigned DefTxIdWidth      = 2;
   localparam int unsigned DefMaxOutstanding = 4;

   // Width of a port index; a single port still needs one tag bit
   function automatic int unsigned calc_port_w(input int unsigned num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   localparam int unsigned ArbPortW = calc_port_w(DefNumPorts);

   // One client request as seen at the arbiter inputs (default widths)
   typedef struct packed {
      logic [DefAddrWidth-1:0] addr;
      logic [DefDataWidth-1:0] wdata;
      logic                    we;
      logic [DefTxIdWidth-1:0] tid;
   } arb_port_req_t;

   // Memory-side tag: owning port in the upper bits, client-local id below
   typedef struct packed {
      logic [ArbPortW-1:0]     port;
      logic [DefTxIdWidth-1:0] tid;
   } mem_arb_tag_t;

endpackage

// File: rtl/wt_rr_arbiter.sv
// Single-grant arbiter: round-robin from a rotating pointer, or fixed
// lowest-index priority when FixedPrio is set. Pick is combinational.
module wt_rr_arbiter
   import wt_mem_req_arbiter_pkg::*;
#(
   parameter  int unsigned NumPorts  = DefNumPorts,
   parameter  bit          FixedPrio = 1'b0,
   localparam int unsigned PortW     = calc_port_w(NumPorts)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NumPorts-1:0] req_i,
   input  logic                en_i,
   output logic [NumPorts-1:0] gnt_o,
   output logic                gnt_vld_o
);

   logic [PortW-1:0] ptr_q, ptr_d;
   logic [PortW-1:0] start;
   logic [PortW:0]   sum;
   logic [PortW-1:0] idx;

   // Walk the ports starting at the search origin and grant the first requester
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      gnt_o     = '0;
      gnt_vld_o = 1'b0;
      ptr_d     = ptr_q;
      sum       = '0;
      idx       = '0;
      start     = FixedPrio ? '0 : ptr_q;
      if (en_i) begin
         for (int i = 0; i < NumPorts; i++) begin
            sum = {1'b0, start} + (PortW+1)'(i);
            if (sum >= (PortW+1)'(NumPorts)) begin
               sum = sum - (PortW+1)'(NumPorts);
            end
            idx = sum[PortW-1:0];
            if (!gnt_vld_o && req_i[idx]) begin
               gnt_o[idx] = 1'b1;
               gnt_vld_o  = 1'b1;
               ptr_d      = (32'(idx) + 1 == NumPorts) ? '0 : idx + 1'b1;
            end
         end
      end
   end

   // Pointer moves past the winner; holds when nothing is granted
   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // register samples its inputs from before the clock edge.
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/wt_mem_req_arbiter.sv
// Arbitrates NumPorts cache/PTW clients onto one memory request channel,
// tags requests with {port, local id}, limits in-flight transactions per
// port and routes returns back to the owning port.
module wt_mem_req_arbiter
   import wt_mem_req_arbiter_pkg::*;
#(
   parameter  int unsigned NumPorts       = DefNumPorts,
   parameter  int unsigned AddrWidth      = DefAddrWidth,
   parameter  int unsigned DataWidth      = DefDataWidth,
   parameter  int unsigned TxIdWidth      = DefTxIdWidth,
   parameter  int unsigned MaxOutstanding = DefMaxOutstanding,
   parameter  bit          FixedPrio      = 1'b0,
   localparam int unsigned PortW          = calc_port_w(NumPorts)
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NumPorts-1:0]            port_req_i,
   output logic [NumPorts-1:0]            port_ack_o,
   input  logic [NumPorts*AddrWidth-1:0]  port_addr_i,
   input  logic [NumPorts*DataWidth-1:0]  port_wdata_i,
   input  logic [NumPorts-1:0]            port_we_i,
   input  logic [NumPorts*TxIdWidth-1:0]  port_tid_i,
   output logic [NumPorts-1:0]            port_rtrn_vld_o,
   output logic [DataWidth-1:0]           port_rtrn_data_o,
   output logic [TxIdWidth-1:0]           port_rtrn_tid_o,
   output logic                           mem_req_vld_o,
   input  logic                           mem_req_rdy_i,
   output logic [AddrWidth-1:0]           mem_addr_o,
   output logic [DataWidth-1:0]           mem_wdata_o,
   output logic                           mem_we_o,
   output logic [PortW+TxIdWidth-1:0]     mem_tid_o,
   input  logic                           mem_rtrn_vld_i,
   input  logic [DataWidth-1:0]           mem_rtrn_data_i,
   input  logic [PortW+TxIdWidth-1:0]     mem_rtrn_tid_i,
   output logic                           busy_o,
   output logic                           err_o
);

   localparam int unsigned TagW = PortW + TxIdWidth;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

   // Request register contents, sized by this instance's parameters
   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] wdata;
      logic                 we;
      logic [TagW-1:0]      tag;
   } req_t;

   req_t                 req_q, req_d;
   logic                 req_vld_q, req_vld_d;
   logic [CntW-1:0]      cnt_q [NumPorts];
   logic [CntW-1:0]      cnt_d [NumPorts];
   logic [NumPorts-1:0]  elig;
   logic [NumPorts-1:0]  gnt;
   logic                 gnt_vld;
   logic                 grant_en;
   logic [PortW-1:0]     rtrn_port;
   logic [NumPorts-1:0]  rtrn_hit;
   logic                 rtrn_err;
   logic                 cnt_any;
   logic [NumPorts-1:0]  rtrn_vld_q;
   logic [DataWidth-1:0] rtrn_data_q;
   logic [TxIdWidth-1:0] rtrn_tid_q;
   logic                 err_q;

   // A new request may enter when the register is empty or is draining this cycle
   assign grant_en = !rst_i && (!req_vld_q || mem_req_rdy_i);

   // A port competes only while it has room for another transaction
   always_comb begin
      elig = '0;
      for (int p = 0; p < NumPorts; p++) begin
         elig[p] = port_req_i[p] && (cnt_q[p] < CntMax);
      end
   end

   wt_rr_arbiter #(
      .NumPorts  (NumPorts),
      .FixedPrio (FixedPrio)
   ) u_rr_arbiter (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (elig),
      .en_i      (grant_en),
      .gnt_o     (gnt),
      .gnt_vld_o (gnt_vld)
   );

   assign port_ack_o = gnt;

   // Load the winning port's request, or empty the register once memory takes it
   always_comb begin
      req_d     = req_q;
      req_vld_d = req_vld_q;
      if (gnt_vld) begin
         req_vld_d = 1'b1;
         for (int p = 0; p < NumPorts; p++) begin
            if (gnt[p]) begin
               req_d.addr  = port_addr_i[p*AddrWidth +: AddrWidth];
               req_d.wdata = port_wdata_i[p*DataWidth +: DataWidth];
               req_d.we    = port_we_i[p];
               req_d.tag   = {PortW'(p), port_tid_i[p*TxIdWidth +: TxIdWidth]};
            end
         end
      end else if (mem_req_rdy_i) begin
         req_vld_d = 1'b0;
      end
   end

   // A return is legal only for an existing port that has something in flight
   assign rtrn_port = mem_rtrn_tid_i[TagW-1 -: PortW];

   always_comb begin
      rtrn_hit = '0;
      for (int p = 0; p < NumPorts; p++) begin
         rtrn_hit[p] = mem_rtrn_vld_i && (rtrn_port == PortW'(p)) && (cnt_q[p] != '0);
      end
   end

   assign rtrn_err = mem_rtrn_vld_i && !(|rtrn_hit);

   // Per-port in-flight count: up on ack, down on legal return, both cancel
   always_comb begin
      cnt_any = 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
         cnt_d[p] = cnt_q[p];
         if (gnt[p] && !rtrn_hit[p]) begin
            cnt_d[p] = cnt_q[p] + CntW'(1);
         end else if (!gnt[p] && rtrn_hit[p]) begin
            cnt_d[p] = cnt_q[p] - CntW'(1);
         end
         cnt_any = cnt_any || (cnt_q[p] != '0);
      end
   end

   // Request register, counters and return register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the data registers are reset too, so every output reads 0
         // out of reset rather than stale data.
         req_q       <= '0;
         req_vld_q   <= 1'b0;
         rtrn_vld_q  <= '0;
         rtrn_data_q <= '0;
         rtrn_tid_q  <= '0;
         err_q       <= 1'b0;
         for (int p = 0; p < NumPorts; p++) begin
            cnt_q[p] <= '0;
         end
      end else begin
         req_q      <= req_d;
         req_vld_q  <= req_vld_d;
         rtrn_vld_q <= rtrn_hit;
         err_q      <= rtrn_err;
         if (|rtrn_hit) begin
            rtrn_data_q <= mem_rtrn_data_i;
            rtrn_tid_q  <= mem_rtrn_tid_i[TxIdWidth-1:0];
         end
         for (int p = 0; p < NumPorts; p++) begin
            cnt_q[p] <= cnt_d[p];
         end
      end
   end

   assign mem_req_vld_o    = req_vld_q;
   assign mem_addr_o       = req_q.addr;
   assign mem_wdata_o      = req_q.wdata;
   assign mem_we_o         = req_q.we;
   assign mem_tid_o        = req_q.tag;
   assign port_rtrn_vld_o  = rtrn_vld_q;
   assign port_rtrn_data_o = rtrn_data_q;
   assign port_rtrn_tid_o  = rtrn_tid_q;
   assign busy_o           = req_vld_q || cnt_any;
   assign err_o            = err_q;

endmodule

// File: tb/tb_wt_mem_req_arbiter.sv
// Directed bench for wt_mem_req_arbiter: one round-robin instance and one
// fixed-priority instance driven by the same stimulus.
module tb_wt_mem_req_arbiter;

   localparam int NP   = 3;
   localparam int AW   = 64;
   localparam int DW   = 64;
   localparam int TW   = 2;
   localparam int TAGW = 4;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic              rst_i;
   logic [NP-1:0]     port_req_i;
   logic [NP*AW-1:0]  port_addr_i;
   logic [NP*DW-1:0]  port_wdata_i;
   logic [NP-1:0]     port_we_i;
   logic [NP*TW-1:0]  port_tid_i;
   logic              mem_req_rdy_i;
   logic              mem_rtrn_vld_i;
   logic [DW-1:0]     mem_rtrn_data_i;
   logic [TAGW-1:0]   mem_rtrn_tid_i;

   logic [NP-1:0]     port_ack_o,      ack_b;
   logic [NP-1:0]     port_rtrn_vld_o, rtrn_vld_b;
   logic [DW-1:0]     port_rtrn_data_o, rtrn_data_b;
   logic [TW-1:0]     port_rtrn_tid_o, rtrn_tid_b;
   logic              mem_req_vld_o,   req_vld_b;
   logic [AW-1:0]     mem_addr_o,      addr_b;
   logic [DW-1:0]     mem_wdata_o,     wdata_b;
   logic              mem_we_o,        we_b;
   logic [TAGW-1:0]   mem_tid_o,       tid_b;
   logic              busy_o,          busy_b;
   logic              err_o,           err_b;

   wt_mem_req_arbiter #(.FixedPrio(1'b0)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .port_req_i(port_req_i), .port_ack_o(port_ack_o),
      .port_addr_i(port_addr_i), .port_wdata_i(port_wdata_i),
      .port_we_i(port_we_i), .port_tid_i(port_tid_i),
      .port_rtrn_vld_o(port_rtrn_vld_o), .port_rtrn_data_o(port_rtrn_data_o),
      .port_rtrn_tid_o(port_rtrn_tid_o),
      .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_we_o(mem_we_o), .mem_tid_o(mem_tid_o),
      .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_data_i(mem_rtrn_data_i),
      .mem_rtrn_tid_i(mem_rtrn_tid_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   wt_mem_req_arbiter #(.FixedPrio(1'b1)) dut_fixed (
      .clk_i(clk_i), .rst_i(rst_i),
      .port_req_i(port_req_i), .port_ack_o(ack_b),
      .port_addr_i(port_addr_i), .port_wdata_i(port_wdata_i),
      .port_we_i(port_we_i), .port_tid_i(port_tid_i),
      .port_rtrn_vld_o(rtrn_vld_b), .port_rtrn_data_o(rtrn_data_b),
      .port_rtrn_tid_o(rtrn_tid_b),
      .mem_req_vld_o(req_vld_b), .mem_req_rdy_i(mem_req_rdy_i),
      .mem_addr_o(addr_b), .mem_wdata_o(wdata_b),
      .mem_we_o(we_b), .mem_tid_o(tid_b),
      .mem_rtrn_vld_i(mem_rtrn_vld_i), .mem_rtrn_data_i(mem_rtrn_data_i),
      .mem_rtrn_tid_i(mem_rtrn_tid_i),
      .busy_o(busy_b), .err_o(err_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      port_req_i      = '0;
      port_addr_i     = '0;
      port_wdata_i    = '0;
      port_we_i       = '0;
      port_tid_i      = '0;
      mem_req_rdy_i   = 1'b0;
      mem_rtrn_vld_i  = 1'b0;
      mem_rtrn_data_i = '0;
      mem_rtrn_tid_i  = '0;
   endtask

   task automatic do_reset();
      idle();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic set_port(input int p, input logic [AW-1:0] addr, input logic [TW-1:0] tid,
                           input logic we, input logic [DW-1:0] wdata);
      port_addr_i[p*AW +: AW]  = addr;
      port_tid_i[p*TW +: TW]   = tid;
      port_we_i[p]             = we;
      port_wdata_i[p*DW +: DW] = wdata;
   endtask

   logic [2:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset: outputs zero, requests ignored while reset is high
      idle();
      rst_i      = 1'b1;
      port_req_i = 3'b111;
      tick();
      tick();
      #1;
      check("rst_ack",  port_ack_o, 0);
      check("rst_vld",  mem_req_vld_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err",  err_o, 0);
      check("rst_rtrn", port_rtrn_vld_o, 0);
      check("rst_tid",  mem_tid_o, 0);
      rst_i      = 1'b0;
      port_req_i = '0;
      tick();

      // Single read on port 1, tid 2
      mem_req_rdy_i = 1'b1;
      set_port(1, 64'h1000, 2'd2, 1'b0, '0);
      port_req_i = 3'b010;
      #1 check("a_ack", port_ack_o, 3'b010);
      tick();
      port_req_i = '0;
      check("a_vld",  mem_req_vld_o, 1);
      check("a_tid",  mem_tid_o, 4'b0110);
      check("a_addr", mem_addr_o, 64'h1000);
      check("a_we",   mem_we_o, 0);
      tick();
      check("a_vld_drop", mem_req_vld_o, 0);
      check("a_busy",     busy_o, 1);
      mem_rtrn_vld_i  = 1'b1;
      mem_rtrn_tid_i  = 4'b0110;
      mem_rtrn_data_i = 64'hDEAD_BEEF;
      #1 check("a_rtrn_early", port_rtrn_vld_o, 0);
      tick();
      mem_rtrn_vld_i = 1'b0;
      check("a_rtrn_vld",  port_rtrn_vld_o, 3'b010);
      check("a_rtrn_tid",  port_rtrn_tid_o, 2);
      check("a_rtrn_data", port_rtrn_data_o, 64'hDEAD_BEEF);
      check("a_err",       err_o, 0);
      check("a_busy_idle", busy_o, 0);
      tick();
      check("a_rtrn_drop", port_rtrn_vld_o, 0);

      // All ports requesting: round-robin vs fixed priority
      do_reset();
      mem_req_rdy_i = 1'b1;
      port_req_i    = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("b_rr", port_ack_o, rr_exp[i]);
         if (i < 4) check("b_fixed", ack_b, 3'b001);
         else       check("b_fixed_thr", ack_b, 3'b010);
         tick();
      end

      // Port 2 fills its four slots, then is throttled
      do_reset();
      mem_req_rdy_i = 1'b1;
      port_req_i    = 3'b100;
      for (int i = 0; i < 4; i++) begin
         #1 check("c_fill", port_ack_o, 3'b100);
         tick();
      end
      #1 check("c_thr", port_ack_o, 3'b000);
      port_req_i = 3'b111;
      #1 check("c_p0", port_ack_o, 3'b001);
      tick();
      port_req_i = 3'b110;
      #1 check("c_p1", port_ack_o, 3'b010);
      tick();
      port_req_i     = 3'b100;
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_tid_i = 4'b1000;
      #1 check("c_thr_rtrn", port_ack_o, 3'b000);
      tick();
      mem_rtrn_vld_i = 1'b0;
      check("c_rtrn_vld", port_rtrn_vld_o, 3'b100);
      #1 check("c_reack", port_ack_o, 3'b100);
      tick();
      port_req_i = '0;

      // Memory stalls five cycles with the next request held
      do_reset();
      set_port(0, 64'hA0A0, 2'd1, 1'b1, 64'h1111);
      port_req_i = 3'b001;
      #1 check("d_ack", port_ack_o, 3'b001);
      tick();
      set_port(0, 64'hB0B0, 2'd3, 1'b0, 64'h2222);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("d_noack", port_ack_o, 3'b000);
         check("d_vld",   mem_req_vld_o, 1);
         check("d_addr",  mem_addr_o, 64'hA0A0);
         check("d_wdata", mem_wdata_o, 64'h1111);
         check("d_we",    mem_we_o, 1);
         check("d_tid",   mem_tid_o, 4'b0001);
         tick();
      end
      mem_req_rdy_i = 1'b1;
      #1 check("d_resume_ack", port_ack_o, 3'b001);
      tick();
      port_req_i = '0;
      check("d_addr2", mem_addr_o, 64'hB0B0);
      check("d_tid2",  mem_tid_o, 4'b0011);
      tick();
      check("d_vld_drop", mem_req_vld_o, 0);

      // Ack and return on port 0 together at count 3 leaves the count at 3
      do_reset();
      mem_req_rdy_i = 1'b1;
      set_port(0, 64'hC0, 2'd0, 1'b0, '0);
      port_req_i = 3'b001;
      for (int i = 0; i < 3; i++) begin
         #1 check("e_fill", port_ack_o, 3'b001);
         tick();
      end
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_tid_i = 4'b0000;
      #1 check("e_ack_same", port_ack_o, 3'b001);
      tick();
      mem_rtrn_vld_i = 1'b0;
      check("e_rtrn", port_rtrn_vld_o, 3'b001);
      check("e_err",  err_o, 0);
      #1 check("e_last_slot", port_ack_o, 3'b001);
      tick();
      #1 check("e_full", port_ack_o, 3'b000);
      tick();
      port_req_i = '0;

      // Return tag naming a nonexistent port
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_tid_i = 4'b1100;
      tick();
      mem_rtrn_vld_i = 1'b0;
      check("f_bad_port_rtrn", port_rtrn_vld_o, 3'b000);
      check("f_bad_port_err",  err_o, 1);
      tick();
      check("f_err_pulse", err_o, 0);

      // Return to port 0 with nothing outstanding
      do_reset();
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_tid_i = 4'b0000;
      tick();
      mem_rtrn_vld_i = 1'b0;
      check("f_zero_rtrn", port_rtrn_vld_o, 3'b000);
      check("f_zero_err",  err_o, 1);
      check("f_zero_busy", busy_o, 0);

      // Reset with a transaction in flight, then a late return
      do_reset();
      mem_req_rdy_i = 1'b1;
      set_port(1, 64'h2000, 2'd0, 1'b0, '0);
      port_req_i = 3'b010;
      #1 check("g_ack", port_ack_o, 3'b010);
      tick();
      port_req_i = '0;
      check("g_busy", busy_o, 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("g_busy_rst", busy_o, 0);
      check("g_vld_rst",  mem_req_vld_o, 0);
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_tid_i = 4'b0100;
      tick();
      mem_rtrn_vld_i = 1'b0;
      check("g_late_err",  err_o, 1);
      check("g_late_rtrn", port_rtrn_vld_o, 3'b000);
      check("g_late_busy", busy_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
